// File: rtl/adc_sampler.sv
// -----------------------------------------------------------------------------
// adc_sampler
//
// Periodic sampler front-end for a SAR ADC. A small FSM paces conversion
// requests to the SAR. It waits 'div' idle cycles, pulses sar_start and then
// waits for sar_done or a timeout. Captured samples go into a show-ahead FIFO.
//
// Optional feature (macro ADC_SAMPLER_AVG_EN): every four captured samples are
// summed. Only the truncated average (sum >> 2) is pushed into the FIFO. With
// the macro undefined, every captured sample is pushed unmodified and no
// accumulator logic is built.
//
// Parameters:
//   SIZE  - sample width in bits (matches the SAR width)
//   DIV_W - width of the sample-period input 'div'
//   DEPTH - FIFO depth in entries (power of 2, minimum 2)
//
// Ports:
//   clk, rst   - clock; asynchronous active-high reset
//   en         - enables periodic sampling
//   div        - idle cycles between conversions (div=0 gives one WAIT cycle)
//   sar_start  - one-cycle conversion request to the SAR
//   sar_done   - SAR conversion-complete pulse (ignored outside CONV)
//   sar_data   - SAR result, valid while sar_done=1
//   rd_en      - FIFO pop request (ignored while empty)
//   rd_data    - FIFO head entry, show-ahead; 0 while empty
//   empty/full - FIFO status
//   level      - FIFO occupancy
//   ovf        - sticky: a sample was dropped because the FIFO was full
//   tmo        - sticky: a conversion timed out
//   clr        - synchronous clear of ovf and tmo (a coincident set wins)
// -----------------------------------------------------------------------------
module adc_sampler #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIV_W-1:0]       div,
    output logic                   sar_start,
    input  logic                   sar_done,
    input  logic [SIZE-1:0]        sar_data,
    input  logic                   rd_en,
    output logic [SIZE-1:0]        rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   tmo,
    input  logic                   clr
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned TMO_CYC = SIZE + 8;
    localparam int unsigned TW      = $clog2(TMO_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StStart,
        StConv
    } state_e;

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    state_e           state;
    logic [DIV_W-1:0] cnt;       // WAIT down-counter
    logic [TW-1:0]    conv_cnt;  // cycles spent in CONV without sar_done
    logic             start_q;
    logic             push_q;    // sample_q is pushed the cycle after capture
    logic [SIZE-1:0]  sample_q;
    logic             tmo_q;
    logic             conv_end;

    assign conv_end = sar_done || (conv_cnt == TMO_LAST);

    // The pulse is registered on entry to START. It is also gated by en, so
    // dropping en during START issues no request; the FSM then returns to IDLE.
    assign sar_start = start_q & en;
    assign tmo       = tmo_q;

`ifdef ADC_SAMPLER_AVG_EN
    logic [SIZE+1:0] acc;
    logic [1:0]      phase;
    logic [SIZE+1:0] avg_sum;
    logic            to_idle;

    assign avg_sum = acc + {2'b00, sar_data};
    assign to_idle = !en && ((state == StWait) || (state == StStart) ||
                             ((state == StConv) && conv_end));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            conv_cnt <= '0;
            start_q  <= 1'b0;
            push_q   <= 1'b0;
            sample_q <= '0;
            tmo_q    <= 1'b0;
`ifdef ADC_SAMPLER_AVG_EN
            acc      <= '0;
            phase    <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            push_q  <= 1'b0;
            // A timeout later in this block overrides the clear.
            if (clr) begin
                tmo_q <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (en) begin
                        state <= StWait;
                        cnt   <= div;
                    end
                end

                StWait: begin
                    if (!en) begin
                        state <= StIdle;
                    end else if (cnt == '0) begin
                        state   <= StStart;
                        start_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                StStart: begin
                    if (en) begin
                        state    <= StConv;
                        conv_cnt <= '0;
                    end else begin
                        state <= StIdle;
                    end
                end

                StConv: begin
                    if (conv_end) begin
                        if (sar_done) begin
`ifdef ADC_SAMPLER_AVG_EN
                            if (phase == 2'd3) begin
                                sample_q <= avg_sum[SIZE+1:2];
                                push_q   <= 1'b1;
                                acc      <= '0;
                                phase    <= '0;
                            end else begin
                                acc   <= avg_sum;
                                phase <= phase + 2'd1;
                            end
`else
                            sample_q <= sar_data;
                            push_q   <= 1'b1;
`endif
                        end else begin
                            // Timeout: flag it, store nothing, phase untouched.
                            tmo_q <= 1'b1;
                        end
                        state <= en ? StWait : StIdle;
                        cnt   <= div;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase

`ifdef ADC_SAMPLER_AVG_EN
            // A partial average never survives a trip through IDLE.
            if (to_idle) begin
                acc   <= '0;
                phase <= '0;
            end
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Show-ahead FIFO
    // -------------------------------------------------------------------------
    logic [SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic            ovf_q;
    logic            do_pop;
    logic            do_push;
    logic            ovf_set;

    assign empty  = (count == '0);
    assign full   = (count == LVL_FULL);
    assign level  = count;
    assign ovf    = ovf_q;

    assign do_pop  = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push_q & (~full | do_pop);
    assign ovf_set = push_q & full & ~do_pop;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= sample_q;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
            if (clr) begin
                ovf_q <= 1'b0;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// -----------------------------------------------------------------------------
// tb_adc_sampler
//
// Directed bench for adc_sampler (SIZE=8, DIV_W=16, DEPTH=4). A behavioural
// SAR model answers each sar_start after a programmable delay with the next
// value from a queue, or stays silent. Stimulus is applied 2 time units after
// each rising edge. The SAR model and the start monitor act 4 units after it.
// -----------------------------------------------------------------------------
module tb_adc_sampler;

    localparam int SIZE  = 8;
    localparam int DIV_W = 16;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             sar_start;
    logic             sar_done;
    logic [SIZE-1:0]  sar_data;
    logic             rd_en;
    logic [SIZE-1:0]  rd_data;
    logic             empty;
    logic             full;
    logic [2:0]       level;
    logic             ovf;
    logic             tmo;
    logic             clr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          starts[$];
    int          wide_err = 0;
    int          done_cnt = 0;
    bit          sar_auto = 1'b1;
    int          sar_delay = 10;
    logic [7:0]  sar_vals[$];
    bit          prev_start = 1'b0;

    adc_sampler #(
        .SIZE  (SIZE),
        .DIV_W (DIV_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div       (div),
        .sar_start (sar_start),
        .sar_done  (sar_done),
        .sar_data  (sar_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .ovf       (ovf),
        .tmo       (tmo),
        .clr       (clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Start monitor: records the cycle of every sar_start and flags wide pulses.
    initial begin
        forever begin
            @(posedge clk);
            #4;
            if (sar_start) begin
                starts.push_back(cyc);
                if (prev_start) wide_err++;
            end
            prev_start = sar_start;
        end
    end

    // SAR model: done is sampled by the DUT at the end of cycle start+sar_delay.
    initial begin
        sar_done = 1'b0;
        sar_data = '0;
        forever begin
            @(posedge clk);
            #4;
            if (sar_start && sar_auto) begin
                repeat (sar_delay) begin
                    @(posedge clk);
                    #4;
                end
                if (sar_vals.size() > 0) sar_data = sar_vals.pop_front();
                else sar_data = 8'h00;
                sar_done = 1'b1;
                done_cnt++;
                @(posedge clk);
                #4;
                sar_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        starts.delete();
        sar_vals.delete();
        done_cnt  = 0;
        sar_auto  = 1'b1;
        sar_delay = 10;
    endtask

    task automatic wait_done(input int n, input string name);
        int b = 0;
        while (done_cnt < n && b < 400) begin
            tick();
            b++;
        end
        n_tests++;
        if (done_cnt < n) begin
            n_fail++;
            $display("FAIL %s: only %0d conversions completed, required %0d", name, done_cnt, n);
        end
    endtask

    task automatic wait_starts(input int n, input string name);
        int b = 0;
        while (starts.size() < n && b < 400) begin
            tick();
            b++;
        end
        n_tests++;
        if (starts.size() < n) begin
            n_fail++;
            $display("FAIL %s: saw %0d sar_start pulses, required %0d", name, starts.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; rd_en = 1'b0; clr = 1'b0; div = '0;
        tick();
        tick();
        n_tests++; if (sar_start !== 1'b0) begin n_fail++; $display("FAIL reset_sar_start: got %b want 0", sar_start); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_tests++; if (ovf !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b tmo=%b want 0 0", ovf, tmo); end
        n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_periodic();
        int n0;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'hA1; exp_v[1] = 8'hA2; exp_v[2] = 8'hA3;
        do_reset();
        sar_vals.push_back(8'hA1);
        sar_vals.push_back(8'hA2);
        sar_vals.push_back(8'hA3);
        wide_err = 0;
        div = 16'd5;
        n0  = cyc;
        en  = 1'b1;
        wait_done(1, "periodic_first_done");
        // First visible cycle after sar_done: push pending, not yet visible.
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL push_latency_empty: got %b want 1", empty); end
        tick();
        n_tests++; if (empty !== 1'b0 || level !== 3'd1) begin n_fail++; $display("FAIL push_visible: got empty=%b level=%0d want 0 1", empty, level); end
        n_tests++; if (rd_data !== 8'hA1) begin n_fail++; $display("FAIL push_rd_data: got %h want a1", rd_data); end
        wait_starts(3, "periodic_starts");
        en = 1'b0;
        if (starts.size() >= 3) begin
            n_tests++; if (starts[0] - n0 !== 7) begin n_fail++; $display("FAIL first_start_latency: got %0d want 7", starts[0] - n0); end
            n_tests++; if (starts[1] - starts[0] !== 17) begin n_fail++; $display("FAIL period_1: got %0d want 17", starts[1] - starts[0]); end
            n_tests++; if (starts[2] - starts[1] !== 17) begin n_fail++; $display("FAIL period_2: got %0d want 17", starts[2] - starts[1]); end
        end
        n_tests++; if (wide_err !== 0) begin n_fail++; $display("FAIL start_width: got %0d wide pulses want 0", wide_err); end
        repeat (40) tick();
        n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL periodic_level: got %0d want 3", level); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (rd_data !== exp_v[i]) begin n_fail++; $display("FAIL periodic_pop%0d: got %h want %h", i, rd_data, exp_v[i]); end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL periodic_drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h11; exp_v[1] = 8'h12; exp_v[2] = 8'h13; exp_v[3] = 8'h14;
        do_reset();
        for (int i = 0; i < 5; i++) sar_vals.push_back(8'(8'h11 + i));
        div = 16'd2;
        en  = 1'b1;
        wait_done(5, "ovf_done");
        en = 1'b0;
        repeat (3) tick();
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", level); end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rd_data !== exp_v[i]) begin n_fail++; $display("FAIL ovf_pop%0d: got %h want %h", i, rd_data, exp_v[i]); end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got empty=%b want 1", empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_tests++; if (level !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty: got level=%0d empty=%b want 0 1", level, empty); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", ovf); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h22; exp_v[1] = 8'h23; exp_v[2] = 8'h24; exp_v[3] = 8'h25;
        do_reset();
        for (int i = 0; i < 5; i++) sar_vals.push_back(8'(8'h21 + i));
        div = 16'd2;
        en  = 1'b1;
        wait_done(4, "fullpop_fill");
        wait_done(5, "fullpop_fifth");
        // Pop lands on the same edge as the fifth push.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        en    = 1'b0;
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL fullpop_level: got %0d want 4", level); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rd_data !== exp_v[i]) begin n_fail++; $display("FAIL fullpop_pop%0d: got %h want %h", i, rd_data, exp_v[i]); end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int s0;
        int b;
        do_reset();
        sar_auto = 1'b0;
        div = 16'd3;
        en  = 1'b1;
        wait_starts(1, "tmo_first_start");
        if (starts.size() < 1) return;
        s0 = starts[0];
        b  = 0;
        while (cyc < s0 + 16 && b < 100) begin
            tick();
            b++;
        end
        n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0 at conv cycle 16", tmo); end
        tick();
        n_tests++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", tmo); end
        n_tests++; if (empty !== 1'b1 || level !== 3'd0) begin n_fail++; $display("FAIL tmo_no_push: got empty=%b level=%0d want 1 0", empty, level); end
        wait_starts(2, "tmo_second_start");
        en = 1'b0;
        if (starts.size() >= 2) begin
            n_tests++; if (starts[1] - s0 !== 21) begin n_fail++; $display("FAIL tmo_restart: got %0d want 21", starts[1] - s0); end
        end
        repeat (25) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_clr: got %b want 0", tmo); end
    endtask

    task automatic test_en_rst();
        do_reset();
        div = 16'd5;
        en  = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        repeat (20) tick();
        n_tests++; if (starts.size() !== 0) begin n_fail++; $display("FAIL en_drop_wait: got %0d starts want 0", starts.size()); end
        en = 1'b1;
        wait_starts(1, "rst_conv_start");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        en  = 1'b0;
        rst = 1'b0;
        repeat (15) tick();
        n_tests++; if (empty !== 1'b1 || level !== 3'd0) begin n_fail++; $display("FAIL rst_mid_conv: got empty=%b level=%0d want 1 0", empty, level); end
        n_tests++; if (starts.size() !== 1) begin n_fail++; $display("FAIL rst_no_restart: got %0d starts want 1", starts.size()); end
    endtask

    task automatic test_average();
        do_reset();
        sar_vals.push_back(8'h10);
        sar_vals.push_back(8'h20);
        sar_vals.push_back(8'h30);
        sar_vals.push_back(8'h41);
        div = 16'd1;
        en  = 1'b1;
        wait_done(4, "avg_done");
        en = 1'b0;
        repeat (4) tick();
`ifdef ADC_SAMPLER_AVG_EN
        n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL avg_level: got %0d want 1", level); end
        n_tests++; if (rd_data !== 8'h28) begin n_fail++; $display("FAIL avg_value: got %h want 28", rd_data); end
`else
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL raw_level: got %0d want 4", level); end
        n_tests++; if (rd_data !== 8'h10) begin n_fail++; $display("FAIL raw_value: got %h want 10", rd_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_en_rst();
        test_average();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
